// File: rtl/fifo_pkg.sv
// Shared types and widths for the FIFO read-side master and its helpers.
package fifo_pkg;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_RUN   = 2'd1,
        RD_FLUSH = 2'd2
    } rd_state_t;

    localparam int FIFO_DW = 8;   // FIFO word width
    localparam int FIFO_AW = 5;   // FIFO address width (32 words)

endpackage

// File: rtl/fifo_reader_out_buf.sv
// Small circular output buffer: absorbs consumer back-pressure between the
// FIFO capture point and the VALID/READY interface. Head entry is always
// visible combinationally so DATA_OUT is stable while it is not popped.
module out_buf
    import fifo_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW   = $clog2(DEPTH),
    localparam int OW   = PW + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [FIFO_DW-1:0] push_data,
    input  logic               pop,
    output logic [OW-1:0]      occupancy,
    output logic [FIFO_DW-1:0] head_data
);

    logic [FIFO_DW-1:0] mem_reg [DEPTH];
    logic [PW-1:0]      wr_ptr_reg;
    logic [PW-1:0]      rd_ptr_reg;
    logic [OW-1:0]      count_reg;
    logic [OW-1:0]      count_next;
    logic               pop_ok;

    // A pop on an empty buffer is meaningless; drop it.
    assign pop_ok    = pop && (count_reg != '0);
    assign occupancy = count_reg;
    assign head_data = mem_reg[rd_ptr_reg];

    // Storage: each entry loads when the write pointer selects it on a push.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mem_reg[gi] <= '0;
                end else if (push && (wr_ptr_reg == PW'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    // Occupancy update: simultaneous push and pop cancel out.
    always_comb begin
        count_next = count_reg;
        case ({push, pop_ok})
            2'b10:   count_next = count_reg + OW'(1);
            2'b01:   count_next = count_reg - OW'(1);
            default: count_next = count_reg;
        endcase
    end

    // Pointers and count; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/fifo_reader.sv
// Read-side master for the 8-bit, 32-word FIFO. Issues READ strobes while
// running, captures each word the cycle after its strobe into a small output
// buffer, and hands words to the consumer over VALID/READY.
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int BUF_DEPTH = 2,
    parameter int CNT_W     = 16
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               START,
    input  logic               STOP,
    input  logic               F_EMPTY_N,
    input  logic [FIFO_AW-1:0] USE_DW,
    input  logic [FIFO_DW-1:0] FIFO_DATA,
    output logic               READ,
    output logic [FIFO_DW-1:0] DATA_OUT,
    output logic               VALID,
    input  logic               READY,
    output logic               BUSY,
    output logic               DONE,
    output logic [CNT_W-1:0]   WORD_CNT
);

    localparam int OW = $clog2(BUF_DEPTH) + 1;

    rd_state_t        state_reg;
    rd_state_t        state_next;
    logic             inflight_reg;
    logic             done_reg;
    logic             done_next;
    logic             busy_reg;
    logic [CNT_W-1:0] word_cnt_reg;

    logic [OW-1:0]    occupancy;
    logic [OW:0]      pending;
    logic             read_en;
    logic             pop;
    logic             flush_drained;

    // Words already committed to the buffer: stored plus the one in flight.
    assign pending = {1'b0, occupancy} + {{OW{1'b0}}, inflight_reg};

    assign VALID = (occupancy != '0);
    assign pop   = VALID && READY;

    // Comparing USE_DW against inflight stops a second strobe for a single
    // remaining word whose occupancy update the FIFO has not shown yet.
    assign read_en = (state_reg == RD_RUN) && F_EMPTY_N
                   && (USE_DW > {{(FIFO_AW-1){1'b0}}, inflight_reg})
                   && (pending < (OW+1)'(BUF_DEPTH));

    // Flush is complete once nothing is in flight and the buffer empties,
    // counting a pop of the last word in this very cycle.
    assign flush_drained = !inflight_reg
                         && ((occupancy == '0) || ((occupancy == OW'(1)) && pop));

    assign READ     = read_en;
    assign BUSY     = busy_reg;
    assign DONE     = done_reg;
    assign WORD_CNT = word_cnt_reg;

    out_buf #(
        .DEPTH     (BUF_DEPTH)
    ) u_out_buf (
        .clk       (CLOCK),
        .rst       (RESET),
        .push      (inflight_reg),
        .push_data (FIFO_DATA),
        .pop       (pop),
        .occupancy (occupancy),
        .head_data (DATA_OUT)
    );

    // Next-state logic: START only acts from IDLE, STOP only from RUN.
    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        case (state_reg)
            RD_IDLE: begin
                if (START) begin
                    state_next = RD_RUN;
                end
            end
            RD_RUN: begin
                if (STOP) begin
                    state_next = RD_FLUSH;
                end
            end
            RD_FLUSH: begin
                if (flush_drained) begin
                    state_next = RD_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = RD_IDLE;
        endcase
    end

    // State register plus registered BUSY/DONE so they change on the same edge.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_reg <= RD_IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next != RD_IDLE);
            done_reg  <= done_next;
        end
    end

    // In-flight flag: the FIFO presents the word the cycle after a strobe.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            inflight_reg <= 1'b0;
        end else begin
            inflight_reg <= read_en;
        end
    end

    // Delivered-word counter; wraps freely.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            word_cnt_reg <= '0;
        end else if (pop) begin
            word_cnt_reg <= word_cnt_reg + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader: behavioural FIFO model on the read side,
// consumer monitor on the output side, hand-computed expectations.
module tb_fifo_reader;
    import fifo_pkg::*;

    localparam int BD = 4;
    localparam int CW = 16;

    logic          CLOCK = 1'b0;
    logic          RESET = 1'b1;
    logic          START = 1'b0;
    logic          STOP  = 1'b0;
    logic          READY = 1'b0;
    logic          F_EMPTY_N;
    logic [4:0]    USE_DW;
    logic [7:0]    FIFO_DATA = 8'h00;
    logic          READ;
    logic [7:0]    DATA_OUT;
    logic          VALID;
    logic          BUSY;
    logic          DONE;
    logic [CW-1:0] WORD_CNT;

    int errors = 0;
    int checks = 0;

    always #5 CLOCK = ~CLOCK;

    fifo_reader #(
        .BUF_DEPTH (BD),
        .CNT_W     (CW)
    ) dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .START     (START),
        .STOP      (STOP),
        .F_EMPTY_N (F_EMPTY_N),
        .USE_DW    (USE_DW),
        .FIFO_DATA (FIFO_DATA),
        .READ      (READ),
        .DATA_OUT  (DATA_OUT),
        .VALID     (VALID),
        .READY     (READY),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .WORD_CNT  (WORD_CNT)
    );

    // FIFO model: data appears one cycle after the edge that sampled READ.
    logic [7:0] fmem [64];
    int wr_idx = 0;
    int rd_idx = 0;
    assign USE_DW    = 5'(wr_idx - rd_idx);
    assign F_EMPTY_N = (wr_idx != rd_idx);

    always @(posedge CLOCK) begin
        if (READ) begin
            FIFO_DATA <= fmem[rd_idx[5:0]];
            rd_idx    <= rd_idx + 1;
        end
    end

    // Consumer / protocol monitor.
    logic [7:0] rx [64];
    int rx_n        = 0;
    int read_cnt    = 0;
    int done_cnt    = 0;
    int empty_reads = 0;

    always @(posedge CLOCK) begin
        if (READ) read_cnt <= read_cnt + 1;
        if (READ && !F_EMPTY_N) empty_reads <= empty_reads + 1;
        if (DONE) done_cnt <= done_cnt + 1;
        if (VALID && READY) begin
            rx[rx_n[5:0]] <= DATA_OUT;
            rx_n          <= rx_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] v);
        fmem[wr_idx[5:0]] = v;
        wr_idx = wr_idx + 1;
    endtask

    task automatic pulse_start();
        @(negedge CLOCK) START = 1'b1;
        @(negedge CLOCK) START = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge CLOCK) STOP = 1'b1;
        @(negedge CLOCK) STOP = 1'b0;
    endtask

    task automatic wait_rx(input int target, input int budget);
        for (int k = 0; k < budget && rx_n < target; k++) @(negedge CLOCK);
        chk("rx_timeout", 32'(rx_n >= target), 32'd1);
    endtask

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget && DONE !== 1'b1; k++) @(negedge CLOCK);
        chk("done_seen", 32'(DONE), 32'd1);
        chk("busy_at_done", 32'(BUSY), 32'd0);
        @(negedge CLOCK);
        chk("done_one_cycle", 32'(DONE), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_rx;
        int b_rd;

        // Reset state
        #12;
        chk("rst_read", 32'(READ), 32'd0);
        chk("rst_data", 32'(DATA_OUT), 32'h00);
        chk("rst_valid", 32'(VALID), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_cnt", 32'(WORD_CNT), 32'd0);
        @(negedge CLOCK) RESET = 1'b0;

        // Five words streamed with READY high
        for (int i = 0; i < 5; i++) push_word(8'(8'h11 + i));
        READY = 1'b1;
        b_rx = rx_n; b_rd = read_cnt;
        pulse_start();
        wait_rx(b_rx + 5, 40);
        repeat (3) @(negedge CLOCK);
        chk("t1_reads", 32'(read_cnt - b_rd), 32'd5);
        for (int i = 0; i < 5; i++) chk("t1_word", 32'(rx[b_rx + i]), 32'(8'h11 + i));
        chk("t1_cnt", 32'(WORD_CNT), 32'd5);
        chk("t1_busy", 32'(BUSY), 32'd1);
        pulse_stop();
        wait_done(10);

        // Back-pressure: only BD reads, head word held stable
        READY = 1'b0;
        for (int i = 0; i < 10; i++) push_word(8'(8'h20 + i));
        b_rx = rx_n; b_rd = read_cnt;
        pulse_start();
        repeat (10) @(negedge CLOCK);
        chk("t2_reads_bp", 32'(read_cnt - b_rd), 32'(BD));
        chk("t2_read_low", 32'(READ), 32'd0);
        chk("t2_valid", 32'(VALID), 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge CLOCK);
            chk("t2_hold", 32'(DATA_OUT), 32'h20);
        end
        READY = 1'b1;
        wait_rx(b_rx + 10, 60);
        for (int i = 0; i < 10; i++) chk("t2_word", 32'(rx[b_rx + i]), 32'(8'h20 + i));
        repeat (2) @(negedge CLOCK);
        chk("t2_reads_all", 32'(read_cnt - b_rd), 32'd10);
        chk("t2_cnt", 32'(WORD_CNT), 32'd15);
        pulse_stop();
        wait_done(10);

        // Single word in the FIFO
        push_word(8'h55);
        b_rx = rx_n; b_rd = read_cnt;
        pulse_start();
        repeat (8) @(negedge CLOCK);
        chk("t3_reads", 32'(read_cnt - b_rd), 32'd1);
        chk("t3_rx_n", 32'(rx_n - b_rx), 32'd1);
        chk("t3_word", 32'(rx[b_rx]), 32'h55);
        chk("t3_empty_reads", 32'(empty_reads), 32'd0);
        chk("t3_busy", 32'(BUSY), 32'd1);
        chk("t3_valid", 32'(VALID), 32'd0);
        pulse_stop();
        wait_done(10);

        // STOP with two buffered and one in flight
        READY = 1'b0;
        for (int i = 0; i < 10; i++) push_word(8'(8'h30 + i));
        b_rx = rx_n; b_rd = read_cnt;
        @(negedge CLOCK) START = 1'b1;
        @(negedge CLOCK) START = 1'b0;   // first read cycle
        @(negedge CLOCK);                // second read cycle
        @(negedge CLOCK) STOP = 1'b1;    // third read cycle, STOP sampled at its end
        @(negedge CLOCK) STOP = 1'b0;
        chk("t4_read_off", 32'(READ), 32'd0);
        chk("t4_valid", 32'(VALID), 32'd1);
        chk("t4_head", 32'(DATA_OUT), 32'h30);
        chk("t4_busy", 32'(BUSY), 32'd1);
        READY = 1'b1;
        wait_done(20);
        chk("t4_rx_n", 32'(rx_n - b_rx), 32'd3);
        for (int i = 0; i < 3; i++) chk("t4_word", 32'(rx[b_rx + i]), 32'(8'h30 + i));
        chk("t4_reads", 32'(read_cnt - b_rd), 32'd3);
        chk("t4_cnt", 32'(WORD_CNT), 32'd19);

        // Asynchronous reset mid-transfer; FIFO holds 8'h33..8'h39
        READY = 1'b0;
        b_rd = read_cnt;
        pulse_start();
        repeat (8) @(negedge CLOCK);
        chk("t5_reads", 32'(read_cnt - b_rd), 32'(BD));
        chk("t5_valid_pre", 32'(VALID), 32'd1);
        #2 RESET = 1'b1;
        #1;
        chk("t5_valid", 32'(VALID), 32'd0);
        chk("t5_read", 32'(READ), 32'd0);
        chk("t5_busy", 32'(BUSY), 32'd0);
        chk("t5_cnt", 32'(WORD_CNT), 32'd0);
        chk("t5_data", 32'(DATA_OUT), 32'h00);
        @(negedge CLOCK) RESET = 1'b0;
        READY = 1'b1;
        b_rx = rx_n;
        pulse_start();
        wait_rx(b_rx + 3, 30);
        for (int i = 0; i < 3; i++) chk("t5_word", 32'(rx[b_rx + i]), 32'(8'h37 + i));
        @(negedge CLOCK);
        chk("t5_cnt_after", 32'(WORD_CNT), 32'd3);
        chk("t5_busy_after", 32'(BUSY), 32'd1);

        // Counter wrap
        force dut.word_cnt_reg = 16'hFFFF;
        @(negedge CLOCK);
        chk("t6_forced", 32'(WORD_CNT), 32'hFFFF);
        release dut.word_cnt_reg;
        b_rx = rx_n;
        push_word(8'h77);
        wait_rx(b_rx + 1, 20);
        @(negedge CLOCK);
        chk("t6_word", 32'(rx[b_rx]), 32'h77);
        chk("t6_wrap", 32'(WORD_CNT), 32'd0);

        chk("done_total", 32'(done_cnt), 32'd4);
        chk("empty_reads_total", 32'(empty_reads), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
